// File: rtl/deck_shuffler.sv
// deck_shuffler: in-place shuffler for a card deck held in an external
// single-port synchronous RAM (1-cycle read latency). For each position i
// it picks a partner j and swaps the two words: read i, read j, capture,
// write i, write j, step. Each swap is 6 cycles.
//
// Optional feature macro: SHUFFLER_LFSR_EN
//   defined   -> 16-bit Galois LFSR present; mode=1 selects random partners
//   undefined -> no LFSR; mode is ignored and stride partners are always used
//
// Handshake: start is a level request. It is sampled in IDLE, must stay high
// until finish, and must drop for at least one cycle before a new shuffle.
// Dropping start aborts only in RD_A, NEXT and DONE, so a swap that has begun
// always completes and the RAM keeps holding a permutation.
// dbg_state exposes the FSM state for observation.
module deck_shuffler #(
    parameter int          DECK_SIZE = 52,
    parameter int          ADDR_W    = 6,
    parameter int          DATA_W    = 4,
    parameter int          STRIDE    = 36,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_rd_en,
    output logic              busy,
    output logic [ADDR_W-1:0] pos,
    output logic              finish,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        WR_I  = 3'd4,
        WR_J  = 3'd5,
        NEXT  = 3'd6,
        DONE  = 3'd7
    } state_t;

    // Sums are formed one bit wider than the address so they cannot wrap.
    localparam logic [ADDR_W:0]   DECK_X   = (ADDR_W+1)'(DECK_SIZE);
    localparam logic [ADDR_W:0]   STRIDE_X = (ADDR_W+1)'(STRIDE);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] LAST_I   = ADDR_W'(DECK_SIZE - 1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W-1:0]   j;
    logic [DATA_W-1:0]   card_a;
    logic [DATA_W-1:0]   card_b;
    logic                load_first;
    logic                load_next;
    logic                cap_a;
    logic                cap_b;
    logic [ADDR_W:0]     stride_sum;
    logic [ADDR_W-1:0]   stride_next;
    logic [ADDR_W-1:0]   first_j;
    logic [ADDR_W-1:0]   next_j;

    // Stride partner: j + STRIDE folded back into 0..DECK_SIZE-1.
    always_comb begin
        stride_sum  = {1'b0, j} + STRIDE_X;
        stride_next = (stride_sum >= DECK_X) ? ADDR_W'(stride_sum - DECK_X)
                                             : stride_sum[ADDR_W-1:0];
    end

`ifdef SHUFFLER_LFSR_EN
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;

    logic [15:0]       lfsr;
    logic              mode_q;
    logic [ADDR_W:0]   rand_x;
    logic [ADDR_W-1:0] rand_j;

    // Free-running Galois LFSR, taps 0xB400; advances every cycle out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr <= SEED_EFF;
        else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Mode is latched when a shuffle is accepted and held for the whole pass.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        mode_q <= 1'b0;
        else if (load_first) mode_q <= mode;
    end

    // Random partner: low LFSR bits folded once (2^ADDR_W <= 2*DECK_SIZE).
    always_comb begin
        rand_x  = {1'b0, lfsr[ADDR_W-1:0]};
        rand_j  = (rand_x >= DECK_X) ? ADDR_W'(rand_x - DECK_X) : lfsr[ADDR_W-1:0];
        first_j = mode   ? rand_j : STRIDE_A;
        next_j  = mode_q ? rand_j : stride_next;
    end
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {mode, ^SEED};

    // Stride-only build: partner selection ignores mode.
    always_comb begin
        first_j = STRIDE_A;
        next_j  = stride_next;
    end
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state, datapath strobes and RAM/status outputs decoded from state.
    always_comb begin
        state_nx   = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wren   = 1'b0;
        mem_rd_en  = 1'b0;
        busy       = 1'b1;
        finish     = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load_first = 1'b1;
                    state_nx   = RD_A;
                end
            end
            RD_A: begin
                mem_addr  = i;
                mem_rd_en = 1'b1;
                state_nx  = start ? RD_B : IDLE;
            end
            RD_B: begin
                mem_addr  = j;
                mem_rd_en = 1'b1;
                cap_a     = 1'b1;
                state_nx  = CAP_B;
            end
            CAP_B: begin
                cap_b    = 1'b1;
                state_nx = WR_I;
            end
            WR_I: begin
                mem_addr  = i;
                mem_wdata = card_b;
                mem_wren  = 1'b1;
                state_nx  = WR_J;
            end
            WR_J: begin
                mem_addr  = j;
                mem_wdata = card_a;
                mem_wren  = 1'b1;
                state_nx  = NEXT;
            end
            NEXT: begin
                if (!start) begin
                    state_nx = IDLE;
                end else if (i == LAST_I) begin
                    state_nx = DONE;
                end else begin
                    load_next = 1'b1;
                    state_nx  = RD_A;
                end
            end
            DONE: begin
                busy   = 1'b0;
                finish = 1'b1;
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Position/partner counters and the two captured cards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i      <= '0;
            j      <= '0;
            card_a <= '0;
            card_b <= '0;
        end else begin
            if (load_first) begin
                i <= '0;
                j <= first_j;
            end else if (load_next) begin
                i <= i + ADDR_W'(1);
                j <= next_j;
            end
            if (cap_a) card_a <= mem_rdata;
            if (cap_b) card_b <= mem_rdata;
        end
    end

    assign pos       = i;
    assign dbg_state = state;

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: a small instance (4 cards, stride 1) and a default
// sized instance (52 cards, stride 36) each drive their own behavioural RAM.
// A swap-level model predicts the bus operations of every cycle and the final
// deck; a negedge compare process checks the active DUT against that queue.
module tb_deck_shuffler;

`ifdef SHUFFLER_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif

    localparam logic [15:0] SEED = 16'hACE1;

    // clock / reset
    logic clock;
    logic reset_n;
    always #5 clock = ~clock;

    // small instance signals
    logic       start_s, mode_s;
    logic [5:0] rdata_s, wdata_s;
    logic [1:0] addr_s, pos_s;
    logic       wren_s, rd_s, busy_s, fin_s;
    logic [2:0] dbg_s;

    // default-size instance signals
    logic       start_b, mode_b;
    logic [5:0] rdata_b, wdata_b, addr_b, pos_b;
    logic       wren_b, rd_b, busy_b, fin_b;
    logic [2:0] dbg_b;

    deck_shuffler #(.DECK_SIZE(4), .ADDR_W(2), .DATA_W(6), .STRIDE(1), .SEED(SEED)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(start_s), .mode(mode_s),
        .mem_rdata(rdata_s), .mem_addr(addr_s), .mem_wdata(wdata_s),
        .mem_wren(wren_s), .mem_rd_en(rd_s), .busy(busy_s), .pos(pos_s),
        .finish(fin_s), .dbg_state(dbg_s)
    );

    deck_shuffler #(.DECK_SIZE(52), .ADDR_W(6), .DATA_W(6), .STRIDE(36), .SEED(SEED)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .mode(mode_b),
        .mem_rdata(rdata_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_wren(wren_b), .mem_rd_en(rd_b), .busy(busy_b), .pos(pos_b),
        .finish(fin_b), .dbg_state(dbg_b)
    );

    // behavioural RAMs with 1-cycle read latency and a bulk preload port
    logic [5:0] ram_s [0:3];
    logic [5:0] ram_b [0:63];
    logic [5:0] pre_s [0:3];
    logic [5:0] pre_b [0:63];
    logic       load_req;

    always @(posedge clock) begin
        if (load_req) begin
            for (int k = 0; k < 4; k++)  ram_s[k] <= pre_s[k];
            for (int k = 0; k < 64; k++) ram_b[k] <= pre_b[k];
        end else begin
            if (wren_s) ram_s[addr_s] <= wdata_s;
            if (wren_b) ram_b[addr_b] <= wdata_b;
        end
        if (rd_s) rdata_s <= ram_s[addr_s];
        if (rd_b) rdata_b <= ram_b[addr_b];
    end

    // reference LFSR: reset to SEED, one Galois step per clock out of reset
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    // scoreboard
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [21:0] exp_q[$];
    logic [21:0] obs;
    logic [21:0] e;
    bit          sel;
    bit          cmp_en;
    int          wr_cnt_s, wr_cnt_b;
    int          mdeck [0:63];
    int          deck1 [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // observed bus word: {finish, busy, rd_en, wren, addr, wdata, pos}
    function automatic logic [21:0] mk(input bit f, input bit b, input bit rd, input bit wr,
                                       input int a, input int wd, input int p);
        return {f, b, rd, wr, 6'(a), 6'(wd), 6'(p)};
    endfunction

    always_comb begin
        if (sel) obs = {fin_b, busy_b, rd_b, wren_b, addr_b, wdata_b, pos_b};
        else     obs = {fin_s, busy_s, rd_s, wren_s, 4'b0, addr_s, wdata_s, 4'b0, pos_s};
    end

    // cycle-by-cycle compare against the predicted bus operations
    always @(negedge clock) begin
        if (wren_s) wr_cnt_s++;
        if (wren_b) wr_cnt_b++;
        if (cmp_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bus_op", {10'b0, obs}, {10'b0, e});
            if (sel && rd_b) check("j_range", {31'b0, addr_b < 6'd52}, 32'd1);
        end
    end

    function automatic int fold(input logic [15:0] l, input int n, input int aw);
        int r;
        r = int'(l) & ((1 << aw) - 1);
        return (r >= n) ? r - n : r;
    endfunction

    // Swap-level model: visit i = 0..stop_k, swap deck[i] with deck[j],
    // emitting the six bus operations each swap must show.
    task automatic build(input int n, input int stride, input bit rnd, input int aw,
                         input logic [15:0] l0, input int stop_k);
        logic [15:0] l;
        int j, a, b;
        l = l0;
        j = rnd ? fold(l, n, aw) : stride;
        for (int k = 0; k < n; k++) begin
            a = mdeck[k];
            b = mdeck[j];
            exp_q.push_back(mk(0, 1, 1, 0, k, 0, k));
            exp_q.push_back(mk(0, 1, 1, 0, j, 0, k));
            exp_q.push_back(mk(0, 1, 0, 0, 0, 0, k));
            exp_q.push_back(mk(0, 1, 0, 1, k, b, k));
            exp_q.push_back(mk(0, 1, 0, 1, j, a, k));
            exp_q.push_back(mk(0, 1, 0, 0, 0, 0, k));
            mdeck[k] = b;
            mdeck[j] = a;
            if (k == stop_k) break;
            for (int s = 0; s < 6; s++) l = lfsr_step(l);
            j = rnd ? fold(l, n, aw) : (j + stride) % n;
        end
    endtask

    // driver tasks
    task automatic drive_start(input bit s, input bit v, input bit md);
        if (s) begin start_b = v; mode_b = md; end
        else   begin start_s = v; mode_s = md; end
    endtask

    function automatic bit fin_of(input bit s);
        return s ? fin_b : fin_s;
    endfunction

    function automatic int ram_at(input bit s, input int k);
        return s ? int'(ram_b[k]) : int'(ram_s[k]);
    endfunction

    task automatic preload(input bit identity);
        for (int k = 0; k < 4; k++)  pre_s[k] = 6'(k);
        for (int k = 0; k < 64; k++) pre_b[k] = identity ? 6'(k) : 6'($urandom_range(0, 63));
        @(posedge clock); #1 load_req = 1'b1;
        @(posedge clock); #1 load_req = 1'b0;
    endtask

    task automatic check_deck(input bit s, input int n, input string tag);
        for (int k = 0; k < n; k++) check(tag, ram_at(s, k), mdeck[k]);
    endtask

    task automatic perm_check(input string tag);
        int hist [0:63];
        int bad;
        bad = 0;
        for (int k = 0; k < 64; k++) hist[k] = 0;
        for (int k = 0; k < 52; k++) hist[ram_b[k]]++;
        for (int v = 0; v < 52; v++) if (hist[v] != 1) bad++;
        check(tag, bad, 0);
    endtask

    // Full shuffle: start held until finish, three DONE cycles, then release.
    task automatic run_full(input bit s, input int n, input int stride, input bit md,
                            input bit rnd, input int aw, input int exp_fin, input string tag);
        int edges;
        logic [15:0] l0;
        sel = s;
        @(posedge clock); #1;
        l0 = m_lfsr;
        for (int k = 0; k < n; k++) mdeck[k] = s ? int'(pre_b[k]) : int'(pre_s[k]);
        exp_q.delete();
        build(n, stride, rnd, aw, l0, n - 1);
        repeat (3) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, n - 1));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, n - 1));
        drive_start(s, 1'b1, md);
        @(posedge clock); #1;
        edges  = 1;
        cmp_en = 1'b1;
        while (!fin_of(s) && edges < exp_fin + 20) begin
            @(posedge clock); #1;
            edges++;
        end
        check({tag, "_finish_cycle"}, edges, exp_fin);
        @(posedge clock); #1;
        @(posedge clock); #1;
        drive_start(s, 1'b0, md);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check({tag, "_ops_left"}, exp_q.size(), 0);
        cmp_en = 1'b0;
        exp_q.delete();
        check_deck(s, n, {tag, "_deck"});
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clock = 1'b0; reset_n = 1'b0; load_req = 1'b0;
        start_s = 1'b0; mode_s = 1'b0; start_b = 1'b0; mode_b = 1'b0;
        sel = 1'b0; cmp_en = 1'b0; wr_cnt_s = 0; wr_cnt_b = 0;
        #12;
        // reset values
        check("por_small_outputs", {8'b0, fin_s, busy_s, rd_s, wren_s, addr_s, wdata_s, pos_s, dbg_s}, 0);
        check("por_big_addr",  addr_b, 0);
        check("por_big_wdata", wdata_b, 0);
        check("por_big_ctrl",  {fin_b, busy_b, rd_b, wren_b}, 0);
        check("por_big_pos",   pos_b, 0);
        check("por_big_state", dbg_b, 0);
        @(posedge clock); #3 reset_n = 1'b1;

        // 4 cards, stride 1: [0,1,2,3] -> [0,2,3,1], finish at cycle 25, 8 writes
        preload(1'b1);
        wr_cnt_s = 0;
        run_full(1'b0, 4, 1, 1'b0, 1'b0, 2, 25, "small_stride");
        check("small_lit0", ram_s[0], 0);
        check("small_lit1", ram_s[1], 2);
        check("small_lit2", ram_s[2], 3);
        check("small_lit3", ram_s[3], 1);
        check("small_writes", wr_cnt_s, 8);

        // 4 cards, mode 1 (random when built in, otherwise identical to stride)
        preload(1'b1);
        run_full(1'b0, 4, 1, 1'b1, LFSR_ON, 2, 25, "small_mode1");
`ifndef SHUFFLER_LFSR_EN
        check("small_mode1_lit0", ram_s[0], 0);
        check("small_mode1_lit1", ram_s[1], 2);
        check("small_mode1_lit2", ram_s[2], 3);
        check("small_mode1_lit3", ram_s[3], 1);
`endif

        // 52 cards, stride mode: identity and a random preload
        preload(1'b1);
        run_full(1'b1, 52, 36, 1'b0, 1'b0, 6, 313, "big_stride");
        perm_check("big_stride_perm");
        preload(1'b0);
        run_full(1'b1, 52, 36, 1'b0, 1'b0, 6, 313, "big_stride_rnd_deck");

        // abort: drop start during WR_I of swap 10
        begin
            int edges;
            preload(1'b1);
            sel = 1'b1;
            @(posedge clock); #1;
            for (int k = 0; k < 52; k++) mdeck[k] = int'(pre_b[k]);
            exp_q.delete();
            build(52, 36, 1'b0, 6, m_lfsr, 10);
            repeat (2) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 10));
            wr_cnt_b = 0;
            drive_start(1'b1, 1'b1, 1'b0);
            @(posedge clock); #1;
            edges  = 1;
            cmp_en = 1'b1;
            while (edges < 64) begin
                @(posedge clock); #1;
                edges++;
            end
            drive_start(1'b1, 1'b0, 1'b0);
            repeat (5) begin @(posedge clock); #1; end
            check("abort_ops_left", exp_q.size(), 0);
            cmp_en = 1'b0;
            exp_q.delete();
            check("abort_busy", busy_b, 0);
            check("abort_state", dbg_b, 0);
            check("abort_writes", wr_cnt_b, 22);
            perm_check("abort_perm");
            check_deck(1'b1, 52, "abort_deck");
        end

        // asynchronous reset mid-operation
        preload(1'b1);
        sel = 1'b1;
        drive_start(1'b1, 1'b1, 1'b0);
        repeat (100) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("arst_addr",  addr_b, 0);
        check("arst_wdata", wdata_b, 0);
        check("arst_ctrl",  {fin_b, busy_b, rd_b, wren_b}, 0);
        check("arst_pos",   pos_b, 0);
        check("arst_state", dbg_b, 0);
        drive_start(1'b1, 1'b0, 1'b0);
        @(posedge clock); #3 reset_n = 1'b1;

        // mode 1 twice from reset: same deck both times, sequence from SEED
        preload(1'b1);
        run_full(1'b1, 52, 36, 1'b1, LFSR_ON, 6, 313, "big_mode1_run1");
        perm_check("big_mode1_perm1");
        for (int k = 0; k < 52; k++) deck1[k] = int'(ram_b[k]);
        @(posedge clock); #3 reset_n = 1'b0;
        @(posedge clock); #3 reset_n = 1'b1;
        preload(1'b1);
        run_full(1'b1, 52, 36, 1'b1, LFSR_ON, 6, 313, "big_mode1_run2");
        perm_check("big_mode1_perm2");
        begin
            int diff;
            diff = 0;
            for (int k = 0; k < 52; k++) if (int'(ram_b[k]) != deck1[k]) diff++;
            check("mode1_repeatable", diff, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
